// File: rtl/frame_packer_serial.sv
// Serial frame packer: accepts a parallel payload word and emits
// SYNC_WORD, the payload and a CRC-8 (poly 0x07) MSB-first over a
// valid/ready bit stream towards the Manchester encoder.
// Legal DATA_W values are multiples of 8 in the range 8..64.
module frame_packer_serial #(
  parameter logic [7:0]  SYNC_WORD = 8'hD5,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk_160m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W     = $clog2(DATA_W);
  localparam int unsigned SYNC_BITS = 8;
  localparam int unsigned CRC_BITS  = 8;
  localparam logic [7:0]  CRC_POLY  = 8'h07;

  localparam logic [CNT_W-1:0] CNT_SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC_LAST  = CNT_W'(CRC_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_CRC  = 2'd3
  } state_e;

  // One serial CRC-8 step for a single payload bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC_POLY : 8'h00);
  endfunction

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [DATA_W-1:0]   shift_q,      shift_d;
  logic [7:0]          crc_q,        crc_d;
  logic                bit_out_q,    bit_out_d;
  logic                bit_valid_q,  bit_valid_d;
  logic                data_ready_q, data_ready_d;
  logic                busy_q,       busy_d;
  logic                frame_done_q, frame_done_d;

  logic                handshake;
  logic                accept;
  logic [CNT_W-1:0]    cnt_dec;
  logic [7:0]          crc_next;

  // Handshake qualifiers and helper values shared by the next-state logic.
  always_comb begin
    handshake = bit_valid_q & bit_ready;
    accept    = data_valid & data_ready_q;
    cnt_dec   = cnt_q - CNT_W'(1);
    crc_next  = crc8_step(crc_q, bit_out_q);
  end

  // Next-state and registered-output logic; every bit advance waits for the handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = bit_valid_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        if (accept) begin
          state_d     = ST_SYNC;
          shift_d     = data_in;
          crc_d       = 8'h00;
          cnt_d       = CNT_SYNC_LAST;
          bit_out_d   = SYNC_WORD[7];
          bit_valid_d = 1'b1;
        end
      end

      ST_SYNC: begin
        if (handshake) begin
          if (cnt_q == '0) begin
            state_d   = ST_DATA;
            cnt_d     = CNT_DATA_LAST;
            bit_out_d = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          end else begin
            cnt_d     = cnt_dec;
            bit_out_d = SYNC_WORD[cnt_dec[2:0]];
          end
        end
      end

      ST_DATA: begin
        // The bit being accepted is the one currently on bit_out.
        if (handshake) begin
          crc_d = crc_next;
          if (cnt_q == '0) begin
            state_d   = ST_CRC;
            cnt_d     = CNT_CRC_LAST;
            bit_out_d = crc_next[7];
          end else begin
            cnt_d     = cnt_dec;
            bit_out_d = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      ST_CRC: begin
        if (handshake) begin
          if (cnt_q == '0) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            bit_out_d    = 1'b0;
            bit_valid_d  = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d     = cnt_dec;
            bit_out_d = crc_q[cnt_dec[2:0]];
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
      end
    endcase

    data_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_160m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      crc_q        <= 8'h00;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_packer_serial.sv
// Self-checking bench for frame_packer_serial (DATA_W = 16).
module tb_frame_packer_serial;

  localparam int unsigned DW         = 16;
  localparam int unsigned FRAME_BITS = DW + 16;

  logic          clk_160m = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          busy;
  logic          frame_done;

  frame_packer_serial #(.SYNC_WORD(8'hD5), .DATA_W(DW)) dut (
    .clk_160m  (clk_160m),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk_160m = ~clk_160m;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk_160m) cyc <= cyc + 1;

  // Monitor state (updated at negedge, predicting the following posedge)
  logic obs[$];
  int   acc_list[$];
  int   acc_cyc    = 0;
  int   last_hs    = 0;
  int   fd_cyc     = 0;
  int   fd_count   = 0;
  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;
  logic prev_fd    = 1'b0;

  always @(negedge clk_160m) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_fd    = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!bit_valid || bit_out !== prev_bit) begin
          n_err++;
          $display("FAIL stall_hold cyc=%0d: bit_valid=%b bit_out=%b, required bit_valid=1 bit_out=%b",
                   cyc, bit_valid, bit_out, prev_bit);
        end
      end
      if (data_valid && data_ready) begin
        acc_cyc = cyc + 1;
        acc_list.push_back(cyc + 1);
      end
      if (bit_valid && bit_ready) begin
        obs.push_back(bit_out);
        last_hs = cyc + 1;
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
        n_cmp++;
        if (bit_valid !== 1'b0 || data_ready !== 1'b1 || prev_fd) begin
          n_err++;
          $display("FAIL done_cycle cyc=%0d: bit_valid=%b data_ready=%b prev_done=%b, required 0/1/0",
                   cyc, bit_valid, data_ready, prev_fd);
        end
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      prev_fd    = frame_done;
    end
  end

  // bit_ready driver: 0 always ready, 1 toggle starting low after accept, 2 random stalls
  int rdy_mode   = 0;
  int stall_left = 0;
  always @(posedge clk_160m) begin
    #1;
    case (rdy_mode)
      0: bit_ready = 1'b1;
      1: bit_ready = (((cyc - acc_cyc) % 2) == 1);
      2: begin
        if (stall_left > 0) begin
          bit_ready = 1'b0;
          stall_left--;
        end else begin
          bit_ready = 1'b1;
          if ($urandom_range(0, 15) == 0) stall_left = int'($urandom_range(0, 20));
        end
      end
      default: bit_ready = 1'b0;
    endcase
  end

  // Reference frame: sync byte, payload, remainder of payload*x^8 mod x^8+x^2+x+1.
  function automatic logic [FRAME_BITS-1:0] model_frame(input logic [DW-1:0] p);
    logic [DW+7:0] r;
    r = {p, 8'h00};
    for (int i = DW + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return {8'hD5, p, r[7:0]};
  endfunction

  function automatic logic [FRAME_BITS-1:0] obs_slice(input int base);
    logic [FRAME_BITS-1:0] v;
    v = '0;
    for (int k = 0; k < int'(FRAME_BITS); k++)
      v = {v[FRAME_BITS-2:0], ((base + k) < obs.size()) ? obs[base + k] : 1'b0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_160m);
    #1;
  endtask

  // Present a word and hold data_valid until the packer takes it.
  task automatic offer(input logic [DW-1:0] w);
    int n;
    n = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && n < 200) begin
      tick();
      n++;
    end
    if (!data_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: data_ready=%b after %0d cycles, required 1", data_ready, n);
    end
    tick();
    data_valid = 1'b0;
  endtask

  // Wait for the frame_done count to exceed start; scramble data_in meanwhile.
  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 3000) begin
      data_in = DW'($urandom);
      tick();
      n++;
    end
    if (fd_count < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: frame_done count=%0d, required %0d", fd_count, target);
    end
  endtask

  task automatic wait_obs(input int nbits);
    int n;
    n = 0;
    while (obs.size() < nbits && n < 3000) begin
      tick();
      n++;
    end
    if (obs.size() < nbits) begin
      n_cmp++;
      n_err++;
      $display("FAIL bits_timeout: accepted bits=%0d, required %0d", obs.size(), nbits);
    end
  endtask

  task automatic run_frame(input logic [DW-1:0] w, output logic [FRAME_BITS-1:0] got);
    int start;
    obs.delete();
    start = fd_count;
    offer(w);
    wait_fd(start + 1);
    chk("frame_len", 32'(obs.size()), 32'(FRAME_BITS));
    got = obs_slice(0);
  endtask

  typedef struct {
    logic [DW-1:0]         payload;
    int                    mode;
    logic [FRAME_BITS-1:0] exp_stream;
    int                    exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [FRAME_BITS-1:0] got;
    logic [DW-1:0]         w;
    logic [DW-1:0]         words[3];
    int                    start;
    int                    n_acc;

    // Latency is counted in edges from the accept edge to the edge that
    // registers frame_done (32 edges = frame_done in the 33rd cycle).
    vecs[0] = '{16'h0001, 0, 32'hD5000107, 32};
    vecs[1] = '{16'h0100, 1, 32'hD5010015, 64};
    vecs[2] = '{16'h0000, 0, 32'hD5000000, 32};
    vecs[3] = '{16'hFFFF, 1, 32'hD5FFFF24, 64};
    vecs[4] = '{16'h8000, 0, 32'hD58000B6, 32};

    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    bit_ready  = 1'b0;
    rdy_mode   = 0;

    repeat (3) tick();
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_bit_valid",  32'(bit_valid),  32'd0);
    chk("rst_bit_out",    32'(bit_out),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(data_ready), 32'd1);

    // Directed table
    foreach (vecs[i]) begin
      rdy_mode = vecs[i].mode;
      tick();
      run_frame(vecs[i].payload, got);
      chk($sformatf("vec%0d_stream", i), got, vecs[i].exp_stream);
      chk($sformatf("vec%0d_done_lat", i), 32'(fd_cyc - acc_cyc), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_last_accept", i), 32'(last_hs - acc_cyc), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_idle_after", i), 32'({busy, bit_valid}), 32'd0);
    end

    // Back-to-back frames with data_valid held high
    rdy_mode = 0;
    tick();
    obs.delete();
    acc_list.delete();
    start = fd_count;
    for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    data_in    = words[0];
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      while (!data_ready && n < 200) begin
        tick();
        n++;
      end
      tick();
      if (i < 2) data_in = words[i + 1];
      else       data_valid = 1'b0;
    end
    wait_fd(start + 3);
    chk("b2b_accepts", 32'(acc_list.size()), 32'd3);
    if (acc_list.size() == 3) begin
      chk("b2b_gap01", 32'(acc_list[1] - acc_list[0]), 32'(FRAME_BITS + 1));
      chk("b2b_gap12", 32'(acc_list[2] - acc_list[1]), 32'(FRAME_BITS + 1));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_frame%0d", i), obs_slice(i * int'(FRAME_BITS)), model_frame(words[i]));

    // data_valid pulse while the CRC is being sent
    tick();
    obs.delete();
    start = fd_count;
    n_acc = acc_list.size();
    offer(16'h1234);
    wait_obs(26);
    data_in    = 16'hBEEF;
    data_valid = 1'b1;
    chk("crc_pulse_ready", 32'(data_ready), 32'd0);
    chk("crc_pulse_busy",  32'(busy),       32'd1);
    tick();
    data_valid = 1'b0;
    wait_fd(start + 1);
    chk("crc_pulse_frame", obs_slice(0), model_frame(16'h1234));
    repeat (4) tick();
    chk("crc_pulse_no_accept", 32'(acc_list.size()), 32'(n_acc + 1));
    chk("crc_pulse_idle", 32'(bit_valid), 32'd0);

    // Reset during payload bit 5
    obs.delete();
    start = fd_count;
    offer(16'hA5C3);
    wait_obs(13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bit_valid",  32'(bit_valid),  32'd0);
    chk("midrst_busy",       32'(busy),       32'd0);
    chk("midrst_data_ready", 32'(data_ready), 32'd0);
    chk("midrst_bit_out",    32'(bit_out),    32'd0);
    repeat (2) tick();
    chk("midrst_no_done", 32'(fd_count), 32'(start));
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_after", 32'(data_ready), 32'd1);
    run_frame(16'h3C5A, got);
    chk("midrst_next_frame", got, model_frame(16'h3C5A));

    // Random payloads under random encoder stalls
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      w = DW'($urandom);
      run_frame(w, got);
      chk($sformatf("rand_frame%0d", i), got, model_frame(w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_packer_serial.md
FRAME_PACKER_SERIAL -- requirements
Module: frame_packer_serial

Interface
REQ-001 SHALL provide parameter SYNC_WORD, default 8'hD5, meaning the 8-bit sync pattern sent first in every frame.
REQ-002 SHALL provide parameter DATA_W, default 16, meaning the payload width in bits; legal values are multiples of 8 in the range 8..64.
REQ-003 SHALL provide port clk_160m  input  1  the 160 MHz clock; all logic is in this single clock domain.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port data_in  input  DATA_W  the parallel payload word.
REQ-006 SHALL provide port data_valid  input  1  data_in is valid this cycle.
REQ-007 SHALL provide port data_ready  output  1  the packer can accept a payload word.
REQ-008 SHALL provide port bit_out  output  1  the serial frame bit presented to the Manchester encoder.
REQ-009 SHALL provide port bit_valid  output  1  bit_out is valid.
REQ-010 SHALL provide port bit_ready  input  1  the encoder accepts bit_out this cycle.
REQ-011 SHALL provide port busy  output  1  a frame is in progress (state is not IDLE).
REQ-012 SHALL provide port frame_done  output  1  one-cycle pulse when a frame has been fully sent.

Function
REQ-013 SHALL send each frame MSB-first, in this order: SYNC_WORD (8 bits), then payload (DATA_W bits), then CRC (8 bits); total frame length is DATA_W+16 bits.
REQ-014 SHALL implement an FSM with states IDLE, SYNC, DATA and CRC, plus one bit counter sized for DATA_W.
REQ-015 SHALL drive data_ready = 1 only in IDLE; a payload word is accepted on data_valid && data_ready.
REQ-016 On accept, SHALL latch data_in, clear the CRC register to 8'h00, load the counter and enter SYNC.
REQ-017 SHALL drive the first sync bit on bit_out with bit_valid = 1 in the cycle after accept (registered outputs, latency 1).
REQ-018 SHALL assert bit_valid in SYNC, DATA and CRC, and SHALL deassert it in IDLE.
REQ-019 SHALL advance to the next bit only on bit_valid && bit_ready; the next bit appears on bit_out in the following cycle.
REQ-020 While bit_valid && !bit_ready, SHALL hold bit_out, the state and the counter stable, with no limit on stall length.
REQ-021 SHALL compute the CRC as CRC-8 with polynomial 0x07, init 0x00, no reflection and no final XOR, over payload bits only.
REQ-022 SHALL update the CRC once per accepted payload bit: crc <= {crc[6:0],1'b0} XOR (8'h07 if crc[7] XOR bit, else 8'h00).
REQ-023 SHALL make the CRC bits sent equal the CRC value after the last payload bit, MSB first.
REQ-024 Transitions SHALL be SYNC->DATA after the 8th sync bit is accepted, DATA->CRC after the DATA_W-th payload bit is accepted, and CRC->IDLE after the 8th CRC bit is accepted.
REQ-025 SHALL pulse frame_done for exactly one cycle, in the cycle after the last CRC bit is accepted.
REQ-026 SHALL stay in IDLE at least one cycle between frames; a word with data_valid held high is accepted in that IDLE cycle.
REQ-027 SHALL ignore data_valid outside IDLE: no latch, and the word is not lost because data_ready is low.
REQ-028 SHALL not change bit_out or frame progress when data_in or data_valid change mid-frame.
REQ-029 SHALL, with an encoder that accepts every other cycle, take 2*(DATA_W+16) cycles per frame with no extra bubbles.

Reset
REQ-030 While rst_n = 0, SHALL force state = IDLE, data_ready = 0, bit_out = 0, bit_valid = 0, busy = 0, frame_done = 0, CRC = 8'h00 and counter = 0.
REQ-031 SHALL make data_ready = 1 from the first clock edge after rst_n deasserts.
REQ-032 A reset asserted mid-frame SHALL drop bit_valid immediately (asynchronously), abandon the frame, and not pulse frame_done.

Verification
REQ-033 Payload 16'h0001, bit_ready always 1 -> bit stream D5 00 01 07; frame_done 33 cycles after accept.
REQ-034 Payload 16'h0100, bit_ready toggling 1/0 -> bit stream D5 01 00 15; 64 cycles from first bit_valid to the last accept.
REQ-035 Random bit_ready stalls of 0..20 cycles over 1000 random payloads -> the reference-model stream matches, and bit_out never changes while bit_valid && !bit_ready.
REQ-036 data_valid held high with 3 queued words -> 3 back-to-back frames, each separated by exactly 1 IDLE cycle with bit_valid = 0 and data_ready = 1.
REQ-037 rst_n pulsed low during payload bit 5 -> bit_valid is 0 immediately with no frame_done; the next frame sent after reset is complete and correct.
REQ-038 data_valid pulsed during the CRC state -> that word is not accepted, and the current frame is unchanged.
